// File: rtl/terminal_char_scheduler.sv
// terminal_char_scheduler
//   Merges characters from the host PIA port and the UART console into one
//   stream for the video terminal's rd[7:1]/da/rda_n input. A round-robin
//   arbiter feeds a circular FIFO; a handshake FSM presents one character at
//   a time and waits for the terminal's acknowledge, with timeout recovery.
//   Optional build macro: UPCASE_FOLD_EN folds 'a'..'z' to 'A'..'Z' at the
//   FIFO input (the terminal glyph ROM only holds upper case).
module terminal_char_scheduler #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [6:0]                    host_char,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic [6:0]                    uart_char,
  input  logic                          uart_valid,
  output logic                          uart_ready,
  output logic [7:1]                    rd,
  output logic                          da,
  input  logic                          rda_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Case folding applied to every character before it is stored.
  function automatic logic [6:0] fold_char(input logic [6:0] c);
`ifdef UPCASE_FOLD_EN
    if ((c >= 7'h61) && (c <= 7'h7A)) begin
      fold_char = c - 7'h20;
    end else begin
      fold_char = c;
    end
`else
    fold_char = c;
`endif
  endfunction

  logic [6:0]             mem_r [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [LW-1:0]          count_r;
  logic                   init_done_r;
  logic                   rr_uart_r;
  logic [SYNC_STAGES-1:0] sync_r;
  state_t                 state_r;
  state_t                 next_state_s;
  logic [TW-1:0]          timer_r;
  logic [TW-1:0]          timer_next_s;
  logic [6:0]             rd_r;
  logic [6:0]             rd_next_s;
  logic                   da_r;
  logic                   da_next_s;
  logic                   timeout_err_r;
  logic                   err_set_s;
  logic                   host_grant_s;
  logic                   uart_grant_s;
  logic                   push_s;
  logic                   pop_s;
  logic [6:0]             push_char_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   ack_s;

  assign full_s      = (count_r == LEVEL_FULL);
  assign empty_s     = (count_r == LW'(0));
  assign ack_s       = sync_r[SYNC_STAGES-1];
  assign push_s      = host_grant_s | uart_grant_s;
  assign push_char_s = fold_char(host_grant_s ? host_char : uart_char);

  assign host_ready  = host_grant_s;
  assign uart_ready  = uart_grant_s;
  assign rd          = rd_r;
  assign da          = da_r;
  assign fifo_level  = count_r;
  assign timeout_err = timeout_err_r;
  assign busy        = (!empty_s) || (state_r != ST_IDLE);

  // Round-robin grant: a lone requester always wins, a contested cycle goes to the pointer side.
  always_comb begin
    host_grant_s = 1'b0;
    uart_grant_s = 1'b0;
    if (init_done_r && !full_s) begin
      if (host_valid && uart_valid) begin
        if (rr_uart_r) begin
          uart_grant_s = 1'b1;
        end else begin
          host_grant_s = 1'b1;
        end
      end else if (host_valid) begin
        host_grant_s = 1'b1;
      end else if (uart_valid) begin
        uart_grant_s = 1'b1;
      end else begin
        host_grant_s = 1'b0;
        uart_grant_s = 1'b0;
      end
    end else begin
      host_grant_s = 1'b0;
      uart_grant_s = 1'b0;
    end
  end

  // Readies stay low until the first clock after reset release; pointer moves to the side not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done_r <= 1'b0;
      rr_uart_r   <= 1'b0;
    end else begin
      init_done_r <= 1'b1;
      if (host_grant_s) begin
        rr_uart_r <= 1'b1;
      end else if (uart_grant_s) begin
        rr_uart_r <= 1'b0;
      end else begin
        rr_uart_r <= rr_uart_r;
      end
    end
  end

  // FIFO storage; contents are meaningless outside the occupied window so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_char_s;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Synchronise the terminal acknowledge (active low, asynchronous) into ack_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ~rda_n};
    end
  end

  // Handshake FSM next-state and datapath updates; a timed-out character is simply dropped.
  always_comb begin
    next_state_s = state_r;
    timer_next_s = timer_r;
    rd_next_s    = rd_r;
    da_next_s    = da_r;
    pop_s        = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          rd_next_s    = mem_r[rd_ptr_r];
          pop_s        = 1'b1;
          da_next_s    = 1'b1;
          timer_next_s = '0;
          next_state_s = ST_PRESENT;
        end else begin
          timer_next_s = '0;
        end
      end
      ST_PRESENT: begin
        if (ack_s) begin
          da_next_s    = 1'b0;
          timer_next_s = '0;
          next_state_s = ST_RELEASE;
        end else if (timer_r == TIMER_LAST) begin
          da_next_s    = 1'b0;
          err_set_s    = 1'b1;
          timer_next_s = '0;
          next_state_s = ST_RELEASE;
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          timer_next_s = '0;
          next_state_s = ST_IDLE;
        end else if (timer_r == TIMER_LAST) begin
          err_set_s    = 1'b1;
          timer_next_s = '0;
          next_state_s = ST_IDLE;
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end
      default: begin
        da_next_s    = 1'b0;
        timer_next_s = '0;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Handshake FSM state register and registered terminal outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
      rd_r    <= 7'h00;
      da_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      timer_r <= timer_next_s;
      rd_r    <= rd_next_s;
      da_r    <= da_next_s;
    end
  end

  // Sticky timeout flag; a new timeout in the same cycle beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if (err_set_s) begin
      timeout_err_r <= 1'b1;
    end else if (err_clr) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

endmodule

// File: tb/tb_terminal_char_scheduler.sv
// Bench for terminal_char_scheduler: directed scenarios plus a queue-based
// model of the character stream that is compared against the DUT every cycle.
module tb_terminal_char_scheduler;

  localparam int DEPTH = 8;
  localparam int TOUT  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] host_char = 7'h00;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [6:0] uart_char = 7'h00;
  logic       uart_valid = 1'b0;
  logic       uart_ready;
  logic [7:1] rd;
  logic       da;
  logic       rda_n = 1'b1;
  logic       busy;
  logic [3:0] fifo_level;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [6:0] host_src[$];
  logic [6:0] uart_src[$];
  logic [6:0] model_q[$];
  logic [6:0] out_log[$];
  bit         rr_uart_m = 1'b0;
  bit         prev_da_m = 1'b0;
  bit         pend_host = 1'b0;
  bit         pend_uart = 1'b0;
  logic [6:0] pend_char = 7'h00;
  logic [6:0] held_rd = 7'h00;
  int         low_negs = 0;
  bit         auto_ack = 1'b0;

  terminal_char_scheduler #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TOUT),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_char  (host_char),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .uart_char  (uart_char),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready),
    .rd         (rd),
    .da         (da),
    .rda_n      (rda_n),
    .busy       (busy),
    .fifo_level (fifo_level),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [6:0] fold_m(input logic [6:0] c);
`ifdef UPCASE_FOLD_EN
    if (c inside {[7'h61:7'h7A]}) return c - 7'h20;
`endif
    return c;
  endfunction

  // Model step, run at every falling edge: account for the last rising edge, then predict the next.
  task automatic sb_step();
    logic exp_h;
    logic exp_u;
    if (rst) begin
      model_q.delete();
      pend_host = 1'b0;
      pend_uart = 1'b0;
      rr_uart_m = 1'b0;
      prev_da_m = 1'b0;
      low_negs  = 0;
      chk("rst_ready", {30'd0, host_ready, uart_ready}, 32'd0);
      chk("rst_level", fifo_level, 32'd0);
      chk("rst_da", da, 32'd0);
      chk("rst_rd", rd, 32'd0);
      return;
    end
    if (da && !prev_da_m) begin
      checks++;
      if (model_q.size() == 0) begin
        errors++;
        $display("FAIL da_rise_empty: da rose with rd=%0h, expected no character pending", rd);
      end else begin
        if (rd !== model_q[0]) begin
          errors++;
          $display("FAIL rd_order: got %0h, expected %0h", rd, model_q[0]);
        end
        held_rd = model_q[0];
        out_log.push_back(rd);
        void'(model_q.pop_front());
      end
    end else if (da && prev_da_m) begin
      chk("rd_stable", rd, held_rd);
    end
    if (pend_host || pend_uart) model_q.push_back(pend_char);
    prev_da_m = da;
    chk("level", fifo_level, model_q.size());
    if (model_q.size() > 0) chk("busy_nonempty", busy, 32'd1);
    exp_h = 1'b0;
    exp_u = 1'b0;
    if (low_negs > 0 && model_q.size() < DEPTH) begin
      if (host_valid && uart_valid) begin
        exp_h = !rr_uart_m;
        exp_u = rr_uart_m;
      end else begin
        exp_h = host_valid;
        exp_u = uart_valid;
      end
    end
    low_negs++;
    chk("host_ready", host_ready, exp_h);
    chk("uart_ready", uart_ready, exp_u);
    pend_host = exp_h;
    pend_uart = exp_u;
    pend_char = exp_h ? fold_m(host_char) : fold_m(uart_char);
    if (exp_h) rr_uart_m = 1'b1;
    else if (exp_u) rr_uart_m = 1'b0;
  endtask

  task automatic drive();
    host_valid = (host_src.size() > 0);
    host_char  = (host_src.size() > 0) ? host_src[0] : 7'h00;
    uart_valid = (uart_src.size() > 0);
    uart_char  = (uart_src.size() > 0) ? uart_src[0] : 7'h00;
  endtask

  // One clock: model check at the falling edge, then advance sources 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
    if (pend_host) void'(host_src.pop_front());
    if (pend_uart) void'(uart_src.pop_front());
    if (auto_ack) rda_n = ~da;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_src.delete();
    uart_src.delete();
    out_log.delete();
    auto_ack = 1'b0;
    rda_n = 1'b1;
    err_clr = 1'b0;
    drive();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_da(input logic v, input int max, output int n);
    n = 0;
    while (da !== v && n < max) begin
      tick();
      n++;
    end
    if (da !== v) begin
      checks++;
      errors++;
      $display("FAIL wait_da: da=%0b after %0d cycles, expected %0b", da, n, v);
    end
  endtask

  task automatic run_until_out(input int cnt, input int max);
    int k;
    k = 0;
    while (out_log.size() < cnt && k < max) begin
      tick();
      k++;
    end
    chk("out_count", out_log.size(), cnt);
  endtask

  initial begin
    int n;
    logic [6:0] e2 [8];

    // 1: single host character, manual acknowledge
    do_reset();
    chk("t1_reset_busy", busy, 32'd0);
    chk("t1_reset_err", timeout_err, 32'd0);
    host_src.push_back(7'h41);
    drive();
    tick();
    chk("t1_no_bypass", da, 32'd0);
    chk("t1_level1", fifo_level, 32'd1);
    tick();
    chk("t1_da_rise", da, 32'd1);
    chk("t1_rd", rd, 32'h41);
    rda_n = 1'b0;
    wait_da(1'b0, 8, n);
    chk("t1_ack_cycles", n, 32'd3);
    chk("t1_rd_held", rd, 32'h41);
    tick();
    tick();
    chk("t1_busy_release", busy, 32'd1);
    rda_n = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk("t1_idle_cycles", n, 32'd3);
    chk("t1_busy_end", busy, 32'd0);
    chk("t1_err_end", timeout_err, 32'd0);

    // 2: both requesters contending every cycle
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_src.push_back(7'h31 + 7'(i));
      uart_src.push_back(7'h51 + 7'(i));
    end
    drive();
    run_until_out(8, 300);
    e2 = '{7'h31, 7'h51, 7'h32, 7'h52, 7'h33, 7'h53, 7'h34, 7'h54};
    for (int i = 0; i < 8; i++) begin
      if (i < out_log.size()) chk("t2_order", out_log[i], e2[i]);
    end

    // 3: fill the FIFO with the terminal stalled
    do_reset();
    for (int i = 0; i < 10; i++) host_src.push_back(7'h30 + 7'(i));
    drive();
    for (int i = 0; i < 8; i++) tick();
    chk("t3_level7", fifo_level, 32'd7);
    chk("t3_in_flight", da, 32'd1);
    tick();
    chk("t3_level8", fifo_level, 32'd8);
    chk("t3_full_ready", host_ready, 32'd0);
    tick();
    tick();
    chk("t3_level_hold", fifo_level, 32'd8);
    chk("t3_full_ready2", host_ready, 32'd0);
    auto_ack = 1'b1;
    run_until_out(10, 400);
    for (int i = 0; i < 10; i++) begin
      if (i < out_log.size()) chk("t3_no_overwrite", out_log[i], 7'h30 + 7'(i));
    end

    // 4: timeout recovery and err_clr priority
    do_reset();
    host_src.push_back(7'h45);
    host_src.push_back(7'h46);
    drive();
    wait_da(1'b1, 10, n);
    wait_da(1'b0, 40, n);
    chk("t4_timeout_len", n, TOUT);
    chk("t4_err_set", timeout_err, 32'd1);
    wait_da(1'b1, 10, n);
    chk("t4_next_char", rd, 32'h46);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", timeout_err, 32'd0);
    err_clr = 1'b1;
    wait_da(1'b0, 40, n);
    chk("t4_timeout_len2", n, TOUT - 1);
    chk("t4_set_wins", timeout_err, 32'd1);
    tick();
    chk("t4_clr_after", timeout_err, 32'd0);
    err_clr = 1'b0;

    // 5: reset in the middle of a handshake
    do_reset();
    for (int i = 0; i < 4; i++) host_src.push_back(7'h21 + 7'(i));
    drive();
    for (int i = 0; i < 4; i++) tick();
    chk("t5_pre_level", fifo_level, 32'd3);
    chk("t5_pre_da", da, 32'd1);
    host_src.delete();
    drive();
    rst = 1'b1;
    #1;
    chk("t5_da_drop", da, 32'd0);
    chk("t5_level_clear", fifo_level, 32'd0);
    chk("t5_busy_clear", busy, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t5_stays_idle", da, 32'd0);

    // 6: case folding at the FIFO input
    do_reset();
    auto_ack = 1'b1;
    host_src.push_back(7'h61);
    host_src.push_back(7'h7B);
    drive();
    run_until_out(2, 100);
    if (out_log.size() >= 2) begin
`ifdef UPCASE_FOLD_EN
      chk("t6_fold", out_log[0], 32'h41);
`else
      chk("t6_nofold", out_log[0], 32'h61);
`endif
      chk("t6_brace", out_log[1], 32'h7B);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
